// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: shared replica-state type and replica count for the TMR vote monitor
package cv32e40p_pkg;
  localparam int unsigned TMR_NUM_REP = 3;
  typedef enum logic [1:0] {
    TMR_OK      = 2'd0,
    TMR_SUSPECT = 2'd1,
    TMR_FAILED  = 2'd2
  } tmr_rep_state_e;
endpackage

// File: rtl/cv32e40p_tmr_replica_tracker.sv
// cv32e40p_tmr_replica_tracker: health FSM, streak, error counter and resync handshake of one replica
module cv32e40p_tmr_replica_tracker
  import cv32e40p_pkg::*;
#(
  parameter int unsigned PERSIST_TH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disagree_i,
  input  logic             valid_i,
  input  logic             clear_i,
  input  logic             ack_i,
  output tmr_rep_state_e   state_o,
  output logic [CNT_W-1:0] count_o,
  output logic             req_o
);
  localparam int unsigned SW = $clog2(PERSIST_TH + 1);
  localparam logic [SW:0] TH = (SW + 1)'(PERSIST_TH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  tmr_rep_state_e state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW:0] inc;
  logic d;
  // next state: a FAILED replica only leaves through the resync ack and never counts as disagreeing
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    d        = valid_i & disagree_i & (state_q != TMR_FAILED);
    inc      = {1'b0, streak_q} + (SW + 1)'(1);
    if (state_q == TMR_FAILED) begin
      state_d  = ack_i ? TMR_OK : TMR_FAILED;
      streak_d = (ack_i || valid_i) ? '0 : streak_q;
    end else if (d) begin
      state_d  = (inc >= TH) ? TMR_FAILED : TMR_SUSPECT;
      streak_d = (inc >= TH) ? TH[SW-1:0] : inc[SW-1:0];
    end else if (valid_i) begin
      state_d  = TMR_OK;
      streak_d = '0;
    end
    cnt_d = clear_i ? '0 : (d && cnt_q != '1) ? cnt_q + CNT_ONE : cnt_q;
  end
  // state, streak and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TMR_OK;
      streak_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      cnt_q    <= cnt_d;
    end
  end
  assign state_o = state_q;
  assign count_o = cnt_q;
  assign req_o   = (state_q == TMR_FAILED);
endmodule

// File: rtl/cv32e40p_tmr_vote_monitor.sv
// cv32e40p_tmr_vote_monitor: monitored TMR voter with degraded voting, fault tracking and resync requests
module cv32e40p_tmr_vote_monitor
  import cv32e40p_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned PERSIST_TH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic [NUM_CH*WIDTH-1:0]   res0_i,
  input  logic [NUM_CH*WIDTH-1:0]   res1_i,
  input  logic [NUM_CH*WIDTH-1:0]   res2_i,
  output logic [NUM_CH*WIDTH-1:0]   result_o,
  output logic [2:0]                mismatch_o,
  output logic                      uncorrectable_o,
  output logic                      fatal_o,
  output logic [5:0]                rep_state_o,
  output logic [3*CNT_W-1:0]        err_cnt_o,
  output logic [2:0]                resync_req_o,
  input  logic [2:0]                resync_ack_i,
  input  logic                      clear_i
);
  localparam int unsigned W = NUM_CH * WIDTH;
  logic [W-1:0] res [TMR_NUM_REP];
  logic [W-1:0] maj;
  tmr_rep_state_e st [TMR_NUM_REP];
  logic [2:0] healthy, dis;
  logic [1:0] h_cnt;
  logic unc_d;
  logic [2:0] mismatch_q;
  logic uncorrectable_q;
  assign res[0] = res0_i;
  assign res[1] = res1_i;
  assign res[2] = res2_i;
  // vote: full majority with three healthy replicas, otherwise the lowest-indexed healthy one
  always_comb begin
    healthy  = {st[2] != TMR_FAILED, st[1] != TMR_FAILED, st[0] != TMR_FAILED};
    h_cnt    = {1'b0, healthy[0]} + {1'b0, healthy[1]} + {1'b0, healthy[2]};
    maj      = (res0_i & res1_i) | (res0_i & res2_i) | (res1_i & res2_i);
    result_o = (h_cnt == 2'd3) ? maj :
               healthy[0] ? res0_i :
               healthy[1] ? res1_i :
               healthy[2] ? res2_i : res0_i;
    dis      = {valid_i & healthy[2] & (res2_i != result_o),
                valid_i & healthy[1] & (res1_i != result_o),
                valid_i & healthy[0] & (res0_i != result_o)};
    unc_d    = valid_i & (h_cnt == 2'd2) &
               (!healthy[0] ? (res1_i != res2_i) :
                !healthy[1] ? (res0_i != res2_i) : (res0_i != res1_i));
  end
  // registered disagreement pulses and degraded-vote conflict flag
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q      <= '0;
      uncorrectable_q <= 1'b0;
    end else begin
      mismatch_q      <= dis;
      uncorrectable_q <= unc_d;
    end
  end
  for (genvar r = 0; r < TMR_NUM_REP; r++) begin : g_rep
    cv32e40p_tmr_replica_tracker #(
      .PERSIST_TH(PERSIST_TH),
      .CNT_W     (CNT_W)
    ) u_trk (
      .clk       (clk),
      .rst       (rst),
      .disagree_i(dis[r]),
      .valid_i   (valid_i),
      .clear_i   (clear_i),
      .ack_i     (resync_ack_i[r]),
      .state_o   (st[r]),
      .count_o   (err_cnt_o[r*CNT_W +: CNT_W]),
      .req_o     (resync_req_o[r])
    );
    assign rep_state_o[2*r +: 2] = st[r];
  end
  assign mismatch_o      = mismatch_q;
  assign uncorrectable_o = uncorrectable_q;
  assign fatal_o         = (h_cnt < 2'd2);
endmodule

// File: tb/tb_cv32e40p_tmr_vote_monitor.sv
// tb_cv32e40p_tmr_vote_monitor: directed self-checking bench for the TMR vote monitor
module tb_cv32e40p_tmr_vote_monitor;
  logic clk = 1'b0;
  logic rst, valid, clr;
  logic [127:0] r0, r1, r2;
  logic [2:0] ack;
  logic [127:0] result, result2;
  logic [2:0] mism, mism2, req, req2;
  logic unc, unc2, fatal, fatal2;
  logic [5:0] st, st2;
  logic [23:0] cnt;
  logic [5:0] cnt2;
  int checks = 0;
  int errors = 0;
  localparam logic [31:0] A = 32'h1234_5678;
  logic [127:0] av, flip_c2b0;

  always #5 clk = ~clk;

  cv32e40p_tmr_vote_monitor dut (
    .clk(clk), .rst(rst), .valid_i(valid), .res0_i(r0), .res1_i(r1), .res2_i(r2),
    .result_o(result), .mismatch_o(mism), .uncorrectable_o(unc), .fatal_o(fatal),
    .rep_state_o(st), .err_cnt_o(cnt), .resync_req_o(req), .resync_ack_i(ack), .clear_i(clr)
  );

  cv32e40p_tmr_vote_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .valid_i(valid), .res0_i(r0), .res1_i(r1), .res2_i(r2),
    .result_o(result2), .mismatch_o(mism2), .uncorrectable_o(unc2), .fatal_o(fatal2),
    .rep_state_o(st2), .err_cnt_o(cnt2), .resync_req_o(req2), .resync_ack_i(ack), .clear_i(clr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    av = {4{A}};
    flip_c2b0 = 128'd1 << 64;
    rst = 1'b1; valid = 1'b0; clr = 1'b0; ack = 3'b000;
    r0 = '0; r1 = '0; r2 = '0;
    tick; tick;
    chk("rst_state", st, 6'd0);
    chk("rst_mism", mism, 3'd0);
    chk("rst_unc", unc, 1'b0);
    chk("rst_req", req, 3'd0);
    chk("rst_cnt", cnt, 24'd0);
    chk("rst_fatal", fatal, 1'b0);
    rst = 1'b0; valid = 1'b1; r0 = av; r1 = av; r2 = av;
    #1 chk("t1_result", result, av);
    tick;
    chk("t1_mism", mism, 3'd0);
    chk("t1_state", st, 6'd0);
    chk("t1_cnt", cnt, 24'd0);
    r1 = av ^ flip_c2b0;
    #1 chk("t2_result", result, av);
    tick;
    chk("t2_mism", mism, 3'b010);
    chk("t2_state_suspect", st, 6'b000100);
    chk("t2_cnt1", cnt[15:8], 8'd1);
    r1 = av;
    tick;
    chk("t2_mism_clear", mism, 3'd0);
    chk("t2_state_ok", st, 6'd0);
    chk("t2_cnt1_hold", cnt[15:8], 8'd1);
    ack = 3'b001;
    tick;
    ack = 3'b000;
    chk("ack_ignored_state", st, 6'd0);
    chk("ack_ignored_req", req, 3'd0);
    r2 = av ^ 128'd1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t3_suspect", st, 6'b010000);
      chk("t3_mism", mism, 3'b100);
    end
    tick;
    chk("t3_failed", st, 6'b100000);
    chk("t3_req", req, 3'b100);
    chk("t3_cnt2", cnt[23:16], 8'd4);
    chk("t3_mism4", mism, 3'b100);
    chk("t3_fatal", fatal, 1'b0);
    tick;
    chk("t3_failed_no_mism", mism, 3'd0);
    chk("t3_failed_cnt2", cnt[23:16], 8'd4);
    chk("t3_degraded_result", result, av);
    r2 = av; ack = 3'b100;
    tick;
    ack = 3'b000;
    chk("t3_resync_state", st, 6'd0);
    chk("t3_resync_req", req, 3'd0);
    r2 = av ^ 128'd1;
    repeat (4) tick;
    chk("t4_refail", st, 6'b100000);
    r0 = {4{32'hA}}; r1 = {4{32'hB}}; r2 = {4{32'hC}};
    #1 chk("t4_result", result, {4{32'hA}});
    tick;
    chk("t4_unc", unc, 1'b1);
    chk("t4_mism", mism, 3'b010);
    chk("t4_cnt1", cnt[15:8], 8'd2);
    chk("t4_cnt0", cnt[7:0], 8'd0);
    chk("t4_state", st, 6'b100100);
    repeat (3) tick;
    chk("t4_two_failed", st, 6'b101000);
    chk("t4_fatal", fatal, 1'b1);
    chk("t4_cnt1_final", cnt[15:8], 8'd5);
    chk("t4_unc_held", unc, 1'b1);
    chk("t4_single_result", result, {4{32'hA}});
    tick;
    chk("t4_unc_drop", unc, 1'b0);
    chk("t4_mism_none", mism, 3'd0);
    r0 = av; r1 = av; r2 = av; ack = 3'b110;
    tick;
    ack = 3'b000;
    chk("t4_recover_state", st, 6'd0);
    chk("t4_recover_fatal", fatal, 1'b0);
    chk("t4_recover_req", req, 3'd0);
    r0 = av ^ 128'd1;
    repeat (3) tick;
    r0 = av;
    tick;
    r0 = av ^ 128'd1;
    repeat (2) tick;
    chk("t5_cnt0", cnt[7:0], 8'd5);
    chk("t5_sat_cnt0", cnt2[1:0], 2'd3);
    chk("t5_state", st, 6'b000001);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("t5_clear_all", cnt, 24'd0);
    chk("t5_clear_sat", cnt2[1:0], 2'd0);
    chk("t5_clear_fsm", st, 6'b000001);
    r0 = av;
    tick;
    chk("t6_ok", st, 6'd0);
    r0 = av ^ 128'd1;
    repeat (2) tick;
    chk("t6_suspect", st, 6'b000001);
    chk("t6_cnt0", cnt[7:0], 8'd2);
    valid = 1'b0;
    repeat (5) tick;
    chk("t6_hold_state", st, 6'b000001);
    chk("t6_hold_mism", mism, 3'd0);
    chk("t6_hold_cnt0", cnt[7:0], 8'd2);
    chk("t6_invalid_result", result, av);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t6_rst_state", st, 6'd0);
    chk("t6_rst_req", req, 3'd0);
    chk("t6_rst_cnt", cnt, 24'd0);
    tick;
    chk("t6_post_state", st, 6'd0);
    chk("t6_post_mism", mism, 3'd0);
    repeat (3) tick;
    valid = 1'b1;
    repeat (3) tick;
    chk("t6_streak_cleared", st, 6'b000001);
    chk("t6_mism_after", mism, 3'b001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
